// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle MIPS sequencer.
// Optional feature macro: JAL_EN (adds the JAL state and decode of opcode 3).
package mc_ctrl_pkg;

  // Sequencer states; JAL only exists when the jump-and-link feature is built in.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_LOAD_WB  = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
`ifdef JAL_EN
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13
`else
    S_JUMP     = 4'd12
`endif
  } state_t;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    CLS_MEM     = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_IMM     = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU operation select.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // ALU B operand select.
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Register-file destination select.
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Register-file write data select.
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Immediate ALU op: ori uses OR, addi (and anything else) adds.
  function automatic logic [1:0] imm_alu_op(input logic [5:0] op);
    logic [1:0] res;
    if (op == OP_ORI) begin
      res = ALU_OR;
    end else begin
      res = ALU_ADD;
    end
    return res;
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational opcode -> instruction class and legal flag.
// Optional feature macro: JAL_EN (opcode 3 decodes to CLS_JAL, else illegal).
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       legal
);

  // Classify the opcode; anything unrecognised is flagged illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    legal    = 1'b1;
    case (opcode)
      OP_LW, OP_SW:    op_class = CLS_MEM;
      OP_RTYPE:        op_class = CLS_RTYPE;
      OP_BEQ:          op_class = CLS_BRANCH;
      OP_ADDI, OP_ORI: op_class = CLS_IMM;
      OP_J:            op_class = CLS_JUMP;
`ifdef JAL_EN
      OP_JAL:          op_class = CLS_JAL;
`endif
      default: begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS sequencer driving all datapath strobes.
// Optional feature macro: JAL_EN (jump-and-link support via the JAL state).
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t    state;
  state_t    state_next;
  op_class_t op_class;
  logic      legal;

  mc_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class),
    .legal    (legal)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; memory-wait states hold until mem_ready.
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b = SRCB_IMM_SH2;
        if (!legal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (op_class)
            CLS_MEM:    state_next = S_MEM_ADDR;
            CLS_RTYPE:  state_next = S_EXEC_R;
            CLS_BRANCH: state_next = S_BRANCH;
            CLS_IMM:    state_next = S_EXEC_I;
            CLS_JUMP:   state_next = S_JUMP;
`ifdef JAL_EN
            CLS_JAL:    state_next = S_JAL;
`endif
            default:    state_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_next = S_MEM_RD;
        end else begin
          state_next = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (mem_ready) begin
          state_next = S_LOAD_WB;
        end else begin
          state_next = S_MEM_RD;
        end
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_MEM_WR;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RD;
        mem_to_reg = M2R_ALUOUT;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = imm_alu_op(opcode);
        state_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALUOUT;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
`ifdef JAL_EN
      S_JAL: begin
        // PC already holds PC+4 here, which is the link value.
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = M2R_PC;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
